// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-cycle SLL/SRL/SRA/ROL controller, one bit per cycle,
//            with a start/busy/done handshake and a held result register.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Counter must hold WIDTH itself, since non-rotate shifts clamp to WIDTH.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int CMP_W = (AMT_W > CNT_W) ? AMT_W : CNT_W;

    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_srl = 2'b01;
    localparam logic [1:0] c_op_sra = 2'b10;
    localparam logic [1:0] c_op_rol = 2'b11;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    localparam logic [CMP_W-1:0] c_width = CMP_W'(WIDTH);
    localparam logic [CMP_W-1:0] c_mask  = CMP_W'(WIDTH - 1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_work;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_done;

    logic [CMP_W-1:0] w_b_ext;
    logic [CMP_W-1:0] w_n_ext;
    logic [CNT_W-1:0] w_n;
    logic [WIDTH-1:0] w_step;

    assign w_b_ext = CMP_W'(b);

    // WIDTH is a power of two, so "mod WIDTH" is a mask of the low bits.
    always_comb begin
        w_n_ext = w_b_ext;
        if (op == c_op_rol) begin
            w_n_ext = w_b_ext & c_mask;
        end else if (w_b_ext > c_width) begin
            w_n_ext = c_width;
        end
    end

    assign w_n = CNT_W'(w_n_ext);

    always_comb begin
        w_step = r_work;
        case (r_op)
            c_op_sll: w_step = {r_work[WIDTH-2:0], 1'b0};
            c_op_srl: w_step = {1'b0, r_work[WIDTH-1:1]};
            c_op_sra: w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            c_op_rol: w_step = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
            default:  w_step = r_work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_work   <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start && !abort) begin
                        r_work  <= a;
                        r_op    <= op;
                        r_cnt   <= w_n;
                        r_state <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    // Abort wins even on the final cycle: no done, result untouched.
                    if (abort) begin
                        r_state <= c_st_idle;
                    end else if (r_cnt != '0) begin
                        r_work <= w_step;
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end else begin
                        r_result <= r_work;
                        r_done   <= 1'b1;
                        r_state  <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy   = (r_state == c_st_shift);
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire
